cordic_rr_sched: RTL and testbench

Shared-resource scheduler and sequencer for the CORDIC cosine function. Two requesters submit angles through independent valid/ready ports. A round-robin arbiter grants one request at a time to a single iterative rotation stage. The block steps that stage through `ITERATIONS` micro-rotations, then returns the cosine with the requester's tag on a valid/ready response port. It sits between the angle-producing front ends and any consumer of cosine values, replacing per-requester unrolled CORDIC copies.

---
 rtl/cordic_pkg.sv | 46 ++++
 rtl/cordic_stage.sv | 38 +++
 rtl/cordic_rr_sched.sv | 147 ++++++++++++++
 tb/tb_cordic_rr_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the time-shared CORDIC cosine scheduler:
// gain, arctangent table, angle/result types and the sequencer state encoding.
package cordic_pkg;

    localparam int CORDIC_WIDTH = 23;

    typedef logic signed [CORDIC_WIDTH-1:0] theta_t;
    typedef logic [CORDIC_WIDTH-2:0]        cos_t;

    // Pre-scales x so the rotation gain cancels and x ends at cos(theta).
    localparam theta_t K_GAIN = 23'h136E9D;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // atan(2^-idx) in unsigned Q1.21; entries beyond idx 7 are plain halvings.
    function automatic cos_t atan_lut(input logic [3:0] idx);
        cos_t val;
        case (idx)
            4'd0:    val = 22'h1921FB;
            4'd1:    val = 22'h0ED634;
            4'd2:    val = 22'h07D6DD;
            4'd3:    val = 22'h03FAB7;
            4'd4:    val = 22'h01FF56;
            4'd5:    val = 22'h00FFEB;
            4'd6:    val = 22'h007FFD;
            4'd7:    val = 22'h004000;
            4'd8:    val = 22'h002000;
            4'd9:    val = 22'h001000;
            4'd10:   val = 22'h000800;
            4'd11:   val = 22'h000400;
            4'd12:   val = 22'h000200;
            4'd13:   val = 22'h000100;
            4'd14:   val = 22'h000080;
            default: val = 22'h000040;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC rotation-mode micro-rotation; purely combinational, the
// scheduler owns every register around it.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH = 23
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] z,
    input  logic        [3:0]       shift,
    input  logic        [WIDTH-1:0] atan,
    output logic signed [WIDTH-1:0] x_next,
    output logic signed [WIDTH-1:0] y_next,
    output logic signed [WIDTH-1:0] z_next
);

    logic                    dir_s;
    logic signed [WIDTH-1:0] x_sh_s;
    logic signed [WIDTH-1:0] y_sh_s;

    // Rotate toward zero residual angle; all sums wrap at WIDTH bits.
    always_comb begin
        dir_s  = z[WIDTH-1];
        x_sh_s = x >>> shift;
        y_sh_s = y >>> shift;
        if (dir_s) begin
            x_next = x + y_sh_s;
            y_next = y - x_sh_s;
            z_next = z + $signed(atan);
        end else begin
            x_next = x - y_sh_s;
            y_next = y + x_sh_s;
            z_next = z - $signed(atan);
        end
    end

endmodule

// File: rtl/cordic_rr_sched.sv
// Round-robin scheduler that time-shares one iterative CORDIC stage between
// two angle requesters and returns tagged cosine results.
module cordic_rr_sched
    import cordic_pkg::*;
#(
    parameter int FRACS      = 21,
    parameter int INTS       = 1,
    parameter int WIDTH      = INTS + FRACS + 1,
    parameter int ITERATIONS = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_theta,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_theta,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-2:0] out_cos,
    output logic             out_tag
);

    state_t                  state_r;
    state_t                  state_s;
    logic signed [WIDTH-1:0] x_r;
    logic signed [WIDTH-1:0] y_r;
    logic signed [WIDTH-1:0] z_r;
    logic signed [WIDTH-1:0] x_s;
    logic signed [WIDTH-1:0] y_s;
    logic signed [WIDTH-1:0] z_s;
    logic        [3:0]       iter_r;
    logic                    tag_r;
    logic                    last_r;
    logic                    out_valid_r;
    logic        [WIDTH-2:0] out_cos_r;
    logic                    out_tag_r;
    logic                    grant_a_s;
    logic                    grant_b_s;
    logic                    last_iter_s;

    assign last_iter_s = (iter_r == 4'(ITERATIONS - 1));
    assign a_ready     = grant_a_s;
    assign b_ready     = grant_b_s;
    assign out_valid   = out_valid_r;
    assign out_cos     = out_cos_r;
    assign out_tag     = out_tag_r;

    cordic_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .x      (x_r),
        .y      (y_r),
        .z      (z_r),
        .shift  (iter_r),
        .atan   (WIDTH'(atan_lut(iter_r))),
        .x_next (x_s),
        .y_next (y_s),
        .z_next (z_s)
    );

    // Grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (!reset && state_r == ST_IDLE) begin
            grant_a_s = a_valid && (!b_valid || last_r == REQ_B);
            grant_b_s = b_valid && (!a_valid || last_r == REQ_A);
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_a_s || grant_b_s) state_s = ST_ITER;
                else                        state_s = ST_IDLE;
            end
            ST_ITER: begin
                if (last_iter_s) state_s = ST_DONE;
                else             state_s = ST_ITER;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Datapath, arbitration history and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            iter_r      <= 4'd0;
            tag_r       <= REQ_A;
            last_r      <= REQ_B;
            out_valid_r <= 1'b0;
            out_cos_r   <= '0;
            out_tag_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_a_s || grant_b_s) begin
                        x_r    <= WIDTH'(K_GAIN);
                        y_r    <= '0;
                        z_r    <= grant_b_s ? $signed(b_theta) : $signed(a_theta);
                        tag_r  <= grant_b_s;
                        iter_r <= 4'd0;
                    end
                end
                ST_ITER: begin
                    x_r    <= x_s;
                    y_r    <= y_s;
                    z_r    <= z_s;
                    iter_r <= iter_r + 4'd1;
                    if (last_iter_s) begin
                        out_valid_r <= 1'b1;
                        out_cos_r   <= x_s[WIDTH-2:0];
                        out_tag_r   <= tag_r;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        last_r      <= out_tag_r;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Randomised bench for cordic_rr_sched: a cycle-level transaction model with a
// floating-point cosine reference checks every output on every cycle.
module tb_cordic_rr_sched;

    localparam int W     = 23;
    localparam int ITERS = 15;

    logic          clk;
    logic          reset;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [W-1:0]  a_theta, b_theta;
    logic          out_valid, out_ready, out_tag;
    logic [W-2:0]  out_cos;

    cordic_rr_sched dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_theta   (a_theta),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_theta   (b_theta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cos   (out_cos),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: busy flag, handshake cycle, pending tag/angle, last grant.
    bit            m_busy = 1'b0;
    bit            m_last = 1'b1;
    bit            m_tag = 1'b0;
    bit            m_rst_applied = 1'b1;
    logic [W-1:0]  m_theta = '0;
    int            m_t = 0;
    int            cyc = 0;
    logic          ea, eb, eov;
    logic [W-2:0]  cos_hold = '0;
    int            hs_cnt = 0;
    int            comp_cnt = 0;
    bit            hs_tag_q[$];
    bit            res_tag_q[$];
    int            res_cos_q[$];
    logic [W-1:0]  a_q[$];
    logic [W-1:0]  b_q[$];
    int            gap_mode = 0;
    int            or_mode = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input real exp);
        real d;
        n_vec++;
        d = real'(act) - exp;
        if (d < 0.0) d = -d;
        if (d > 128.0) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, want %0f +/-128", nm, cyc, act, exp);
        end
    endtask

    function automatic real exp_cos(input logic [W-1:0] th);
        return $cos(real'($signed(th)) / 2097152.0) * 2097152.0;
    endfunction

    // Compare process: outputs seen at negedge against the transaction model.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_rst_applied) begin
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_out_cos", longint'(out_cos), 0);
            chk("rst_out_tag", longint'(out_tag), 0);
        end
        if (reset || m_busy) begin
            ea = 1'b0;
            eb = 1'b0;
        end else begin
            ea = a_valid && (!b_valid || m_last);
            eb = b_valid && (!a_valid || !m_last);
        end
        eov = m_busy && (cyc - m_t >= ITERS + 1);
        chk("a_ready", longint'(a_ready), longint'(ea));
        chk("b_ready", longint'(b_ready), longint'(eb));
        chk("out_valid", longint'(out_valid), longint'(eov));
        if (eov) begin
            chk("out_tag", longint'(out_tag), longint'(m_tag));
            if (cyc - m_t == ITERS + 1) begin
                chk_tol("out_cos", int'(out_cos), exp_cos(m_theta));
                cos_hold = out_cos;
            end else begin
                chk("cos_stable", longint'(out_cos), longint'(cos_hold));
            end
        end
        if (reset) begin
            m_busy        = 1'b0;
            m_last        = 1'b1;
            m_rst_applied = 1'b1;
        end else begin
            m_rst_applied = 1'b0;
            if (eov && out_ready) begin
                m_busy = 1'b0;
                m_last = m_tag;
                res_tag_q.push_back(m_tag);
                res_cos_q.push_back(int'(out_cos));
                comp_cnt++;
            end else if (ea || eb) begin
                m_busy  = 1'b1;
                m_t     = cyc;
                m_tag   = eb;
                m_theta = eb ? b_theta : a_theta;
                hs_tag_q.push_back(eb);
                hs_cnt++;
            end
        end
    end

    task automatic step();
        logic ha, hb;
        @(negedge clk);
        ha = a_valid && a_ready;
        hb = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (ha) a_valid = 1'b0;
        if (hb) b_valid = 1'b0;
        if (!a_valid && a_q.size() > 0 && (gap_mode == 0 || $urandom_range(0, 2) == 0)) begin
            a_theta = a_q.pop_front();
            a_valid = 1'b1;
        end
        if (!b_valid && b_q.size() > 0 && (gap_mode == 0 || $urandom_range(0, 2) == 0)) begin
            b_theta = b_q.pop_front();
            b_valid = 1'b1;
        end
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wait_comp(input int n, input int budget);
        int k;
        k = 0;
        while (comp_cnt < n && k < budget) begin
            step();
            k++;
        end
        if (comp_cnt < n) chk("timeout_results", longint'(comp_cnt), longint'(n));
    endtask

    initial begin
        int k, h0, r;
        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_theta = '0;   b_theta = '0;
        out_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Directed angles with hand-computed results.
        a_q.push_back(23'h000000);
        wait_comp(1, 200);
        b_q.push_back(23'h200000);
        wait_comp(2, 200);
        b_q.push_back(23'h600000);
        wait_comp(3, 200);
        chk("tag_zero", longint'(res_tag_q[0]), 0);
        chk_tol("cos_lit_zero", res_cos_q[0], 2097152.0);
        chk("tag_pos1", longint'(res_tag_q[1]), 1);
        chk_tol("cos_lit_pos1", res_cos_q[1], 1133096.0);
        chk("tag_neg1", longint'(res_tag_q[2]), 1);
        chk_tol("cos_lit_neg1", res_cos_q[2], 1133096.0);

        // Sustained contention: grants alternate starting with A.
        for (int i = 0; i < 4; i++) begin
            a_q.push_back(W'(23'h040000 * i));
            b_q.push_back(W'(23'h7C0000 - 23'h030000 * i));
        end
        wait_comp(11, 600);
        for (int i = 0; i < 8; i++)
            chk("grant_order", longint'(hs_tag_q[3 + i]), longint'(i % 2));

        // Back-pressure in DONE with B waiting.
        or_mode = 1;
        a_q.push_back(23'h100000);
        b_q.push_back(23'h0C0000);
        k = 0;
        while (!out_valid && k < 100) begin
            step();
            k++;
        end
        chk("done_reached", longint'(out_valid), 1);
        repeat (10) step();
        or_mode = 0;
        wait_comp(13, 200);

        // Reset mid-rotation aborts the request.
        a_q.push_back(23'h180000);
        h0 = hs_cnt;
        k = 0;
        while (hs_cnt == h0 && k < 50) begin
            step();
            k++;
        end
        repeat (7) step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (20) step();
        chk("abort_no_result", longint'(comp_cnt), 13);
        a_q.push_back(23'h0A0000);
        b_q.push_back(23'h1F0000);
        wait_comp(15, 200);
        chk("post_reset_first_grant", longint'(hs_tag_q[14]), 0);

        // Random legal angles, random gaps and back-pressure.
        gap_mode = 1;
        or_mode  = 2;
        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 32'h400000)) - 32'h200000;
            a_q.push_back(W'(r));
            r = int'($urandom_range(0, 32'h400000)) - 32'h200000;
            b_q.push_back(W'(r));
        end
        wait_comp(75, 6000);
        or_mode = 0;
        repeat (3) step();
        chk("no_loss_or_dup", longint'(hs_cnt), longint'(comp_cnt + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule
